// File: rtl/udc_pkg.sv
// udc_pkg: shared state encoding and direction-indicator segment patterns
package udc_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;
  localparam logic [1:0] TURN = 2'd3;
  localparam logic [6:0] SEG_UP    = 7'b0111110;
  localparam logic [6:0] SEG_DOWN  = 7'b0111101;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/udc_seg_dir.sv
// udc_seg_dir: maps a counter state to its direction-indicator segment pattern
module udc_seg_dir
  import udc_pkg::*;
(
  input  logic [1:0] state,
  output logic [6:0] seg
);
  // only the two running states light an arrow; IDLE and TURN stay blank
  always_comb seg = state == UP ? SEG_UP : state == DOWN ? SEG_DOWN : SEG_BLANK;
endmodule

// File: rtl/udc_mod_counter.sv
// udc_mod_counter: modulo-(MAX+1) up/down counter with turn-around FSM, wrap or saturate
module udc_mod_counter
  import udc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic [6:0]       seg,
  output logic             digit
);
  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];
  logic [WIDTH-1:0] out_q, out_d, nxt;
  logic [1:0]       state_q, state_d;
  logic [6:0]       seg_q, seg_d;
  logic             tc_q, tc_d, orig_q, orig_d;
  logic             stepping, turning, lim;
  // next count, terminal flag and state; orig remembers the direction a TURN came from
  always_comb begin
    stepping = state_q == IDLE || (state_q == UP && dir) || (state_q == DOWN && !dir) ||
               (state_q == TURN && dir != orig_q);
    turning  = (state_q == UP && !dir) || (state_q == DOWN && dir);
    lim      = dir ? out_q == MAXV : out_q == '0;
    nxt      = dir ? (lim ? (SAT ? MAXV : '0) : out_q + 1'b1)
                   : (lim ? (SAT ? '0 : MAXV) : out_q - 1'b1);
    out_d    = load ? (load_val > MAXV ? MAXV : load_val) : (en && stepping) ? nxt : out_q;
    tc_d     = !load && en && stepping && lim;
    state_d  = (load || !en) ? IDLE : turning ? TURN : dir ? UP : DOWN;
    orig_d   = (!load && en && turning) ? !dir : orig_q;
  end
  udc_seg_dir u_seg (
    .state(state_d),
    .seg  (seg_d)
  );
  // all outputs registered; reset blanks the display and aborts any step or turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      state_q <= IDLE;
      orig_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      seg_q   <= seg_d;
      state_q <= state_d;
      orig_q  <= orig_d;
    end
  end
  assign out   = out_q;
  assign tc    = tc_q;
  assign seg   = seg_q;
  assign digit = 1'b1;
endmodule
